cache_port_arbiter: RTL and testbench

- Shares one single-cycle cache (put/get request/response interface) between two requesters, e.g. a core's imem and dmem paths, or two cores.
- Round-robin arbitration on the put side.
- Tracks which requester owns the outstanding response and steers the get-side response back to it.
- Requests with ignore_response set are fire-and-forget and create no ownership.

---
 rtl/cache_port_arbiter_pkg.sv | 45 ++++
 rtl/cache_port_arbiter_if.sv | 27 ++
 rtl/cache_port_arbiter_rr_arb2.sv | 15 +
 rtl/cache_port_arbiter.sv | 115 +++++++++++
 tb/tb_cache_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// Shared cache definitions used by the cache port arbiter and its requesters.
// Holds the request/response field widths, the packed request and response
// row layouts, the arbiter state type and a few helpers.
// No ports (package).
package cache_pkg;

  localparam int BYTE_EN_W = 4;
  localparam int TAG_W     = 18;
  localparam int INDEX_W   = 12;
  localparam int DATA_W    = 32;
  localparam int MSI_W     = 2;

  localparam int REQ_W = BYTE_EN_W + TAG_W + INDEX_W + DATA_W + 1 + MSI_W + 1;
  localparam int ROW_W = TAG_W + DATA_W + MSI_W;

  // Bit position of ignore_response inside a flat request word.
  localparam int IGN_BIT = 0;

  typedef struct packed {
    logic [BYTE_EN_W-1:0] byte_en;
    logic [TAG_W-1:0]     tag;
    logic [INDEX_W-1:0]   index;
    logic [DATA_W-1:0]    data;
    logic                 msi_valid;
    logic [MSI_W-1:0]     msi;
    logic                 ignore_response;
  } cache_req_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [MSI_W-1:0]  msi;
  } cache_row_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Fire-and-forget requests never produce a response.
  function automatic logic is_ignore(input logic [REQ_W-1:0] req);
    return req[IGN_BIT];
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Put/get handshake bundle for one cache port.
//   req_valid / req_ready / req_data    : put side (request toward the cache)
//   resp_valid / resp_ready / resp_data : get side (response back from cache)
// On the cache-facing port, resp_valid is the cache's get_ready and
// resp_ready is the consumer's get_valid.
// Modports: master = the side issuing requests, slave = the side serving them.
interface cache_port_arbiter_if;
  import cache_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [REQ_W-1:0] req_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [ROW_W-1:0] resp_data;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/cache_port_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   valid[1:0]  in  : requesters with a pending request
//   last_grant  in  : requester granted most recently
//   grant       out : chosen requester (0 when nobody is valid)
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant
);

  // On a conflict the requester that did not win last time goes first;
  // otherwise the single valid requester wins.
  assign grant = (&valid) ? ~last_grant : valid[1];

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one single-cycle cache between two requesters.
// Round-robin on the put side, response steered back to the requester that
// owns the outstanding request. Requests with ignore_response set are
// fire-and-forget and create no ownership.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   r0, r1   (slave)             : requester ports; resp_data is broadcast,
//                                  qualified by each port's resp_valid
//   mem      (master)            : cache put/get port
//   stat_grant0/1, stat_conflict : statistics counters
// Optional build macro ARB_STATS_EN enables the statistics counters; without
// it the stat ports are tied to zero.
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int STAT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_port_arbiter_if.slave  r0,
  cache_port_arbiter_if.slave  r1,
  cache_port_arbiter_if.master mem,
  output logic [STAT_W-1:0]    stat_grant0,
  output logic [STAT_W-1:0]    stat_grant1,
  output logic [STAT_W-1:0]    stat_conflict
);

  arb_state_t       st;
  logic             owner;
  logic             last_grant;

  logic [1:0]       req_valid;
  logic             grant;
  logic             owner_ready;
  logic             take;
  logic             can_issue;
  logic             fire;
  logic             ign;
  logic [REQ_W-1:0] grant_req;

  assign req_valid = {r1.req_valid, r0.req_valid};

  rr_arb2 u_rr_arb2 (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign owner_ready = owner ? r1.resp_ready : r0.resp_ready;

  // A response leaves the cache this cycle, freeing it for a new request.
  assign take      = (st == BUSY) && mem.resp_valid && owner_ready;
  assign can_issue = (st == IDLE) || take;

  assign grant_req = grant ? r1.req_data : r0.req_data;
  assign ign       = is_ignore(grant_req);

  // Put side
  assign mem.req_valid = can_issue && (|req_valid);
  assign mem.req_data  = grant_req;
  assign fire          = mem.req_valid && mem.req_ready;

  assign r0.req_ready = can_issue && !grant && mem.req_ready && r0.req_valid;
  assign r1.req_ready = can_issue &&  grant && mem.req_ready && r1.req_valid;

  // Get side
  assign r0.resp_valid  = (st == BUSY) && !owner && mem.resp_valid;
  assign r1.resp_valid  = (st == BUSY) &&  owner && mem.resp_valid;
  assign mem.resp_ready = (st == BUSY) && owner_ready;
  assign r0.resp_data   = mem.resp_data;
  assign r1.resp_data   = mem.resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (fire) begin
        last_grant <= grant;
        if (!ign) owner <= grant;
      end
      // Outside IDLE or a take cycle the state holds: the owner is still
      // waiting on its response and nothing new may issue.
      if (can_issue) st <= (fire && !ign) ? BUSY : IDLE;
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt_grant0;
  logic [STAT_W-1:0] cnt_grant1;
  logic [STAT_W-1:0] cnt_conflict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_grant0   <= '0;
      cnt_grant1   <= '0;
      cnt_conflict <= '0;
    end else begin
      if (fire && !grant) cnt_grant0 <= cnt_grant0 + STAT_W'(1);
      if (fire &&  grant) cnt_grant1 <= cnt_grant1 + STAT_W'(1);
      if ((&req_valid) && can_issue) cnt_conflict <= cnt_conflict + STAT_W'(1);
    end
  end

  assign stat_grant0   = cnt_grant0;
  assign stat_grant1   = cnt_grant1;
  assign stat_conflict = cnt_conflict;
`else
  assign stat_grant0   = '0;
  assign stat_grant1   = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed testbench for cache_port_arbiter with a one-cycle cache model.
module tb_cache_port_arbiter;
  import cache_pkg::*;

  localparam int STAT_W = 32;

  logic clk;
  logic rst;
  logic [STAT_W-1:0] stat_grant0, stat_grant1, stat_conflict;

  int n_checks = 0;
  int n_errors = 0;

  cache_port_arbiter_if r0_if ();
  cache_port_arbiter_if r1_if ();
  cache_port_arbiter_if mem_if ();

  cache_port_arbiter #(.STAT_W(STAT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .r0            (r0_if),
    .r1            (r1_if),
    .mem           (mem_if),
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model: the row for an accepted request is presented next cycle.
  always @(posedge clk)
    if (mem_if.req_valid && mem_if.req_ready)
      mem_if.resp_data <= row_of(mem_if.req_data);

  function automatic cache_req_t mk_req(input logic [11:0] idx, input logic [31:0] data,
                                        input logic [3:0] be, input logic ign);
    cache_req_t r;
    r.byte_en         = be;
    r.tag             = 18'h00100 + 18'(idx);
    r.index           = idx;
    r.data            = data;
    r.msi_valid       = 1'b1;
    r.msi             = 2'b01;
    r.ignore_response = ign;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [REQ_W-1:0] flat);
    cache_req_t r;
    cache_row_t w;
    r = flat;
    w.tag  = r.tag;
    w.data = r.data;
    w.msi  = r.msi;
    return w;
  endfunction

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int g0, input int g1, input int c);
`ifdef ARB_STATS_EN
    check({tag, "_g0"}, 70'(stat_grant0),   70'(g0));
    check({tag, "_g1"}, 70'(stat_grant1),   70'(g1));
    check({tag, "_cf"}, 70'(stat_conflict), 70'(c));
`else
    check({tag, "_g0"}, 70'(stat_grant0),   70'(0));
    check({tag, "_g1"}, 70'(stat_grant1),   70'(0));
    check({tag, "_cf"}, 70'(stat_conflict), 70'(0));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  cache_req_t ra, rb, rc, rd, re, wr, rf, rg, rh, ri, rj;
  int grants;

  initial begin
    ra = mk_req(12'h005, 32'h1111_0005, 4'h0, 1'b0);
    rb = mk_req(12'h006, 32'h2222_0006, 4'h0, 1'b0);
    rc = mk_req(12'h010, 32'h3333_0010, 4'h0, 1'b0);
    rd = mk_req(12'h007, 32'h4444_0007, 4'h0, 1'b0);
    re = mk_req(12'h008, 32'h5555_0008, 4'h0, 1'b0);
    wr = mk_req(12'h020, 32'hDEAD_BEEF, 4'hF, 1'b1);
    rf = mk_req(12'h009, 32'h6666_0009, 4'h0, 1'b0);
    rg = mk_req(12'h00A, 32'h7777_000A, 4'h0, 1'b0);
    rh = mk_req(12'h00B, 32'h8888_000B, 4'h0, 1'b0);
    ri = mk_req(12'h00C, 32'h9999_000C, 4'h0, 1'b0);
    rj = mk_req(12'h00D, 32'hAAAA_000D, 4'h0, 1'b0);

    rst = 1'b1;
    r0_if.req_valid = 1'b0; r0_if.req_data = '0; r0_if.resp_ready = 1'b1;
    r1_if.req_valid = 1'b0; r1_if.req_data = '0; r1_if.resp_ready = 1'b1;
    mem_if.req_ready = 1'b1; mem_if.resp_valid = 1'b1;
    repeat (2) tick();
    check("rst_put_valid", 70'(mem_if.req_valid),  70'(0));
    check("rst_get_valid", 70'(mem_if.resp_ready), 70'(0));
    check("rst_r0_ready",  70'(r0_if.req_ready),   70'(0));
    check("rst_r1_ready",  70'(r1_if.req_ready),   70'(0));
    check("rst_r0_resp",   70'(r0_if.resp_valid),  70'(0));
    check("rst_r1_resp",   70'(r1_if.resp_valid),  70'(0));
    check_stats("rst", 0, 0, 0);
    rst = 1'b0;

    // Conflict after reset: r0 first, then r1 back-to-back.
    r0_if.req_valid = 1'b1; r0_if.req_data = ra;
    r1_if.req_valid = 1'b1; r1_if.req_data = rb;
    #1;
    check("t1_c1_r0_ready", 70'(r0_if.req_ready),  70'(1));
    check("t1_c1_r1_ready", 70'(r1_if.req_ready),  70'(0));
    check("t1_c1_put_req",  70'(mem_if.req_data),  70'(ra));
    tick();
    r0_if.req_valid = 1'b0;
    #1;
    check("t1_c2_r1_ready", 70'(r1_if.req_ready),  70'(1));
    check("t1_c2_r0_resp",  70'(r0_if.resp_valid), 70'(1));
    check("t1_c2_r1_resp",  70'(r1_if.resp_valid), 70'(0));
    check("t1_c2_get_vld",  70'(mem_if.resp_ready), 70'(1));
    check("t1_c2_data",     70'(r0_if.resp_data),  70'(row_of(ra)));
    check("t1_c2_put_req",  70'(mem_if.req_data),  70'(rb));
    tick();
    r1_if.req_valid = 1'b0;
    #1;
    check("t1_c3_r1_resp",  70'(r1_if.resp_valid), 70'(1));
    check("t1_c3_r0_resp",  70'(r0_if.resp_valid), 70'(0));
    check("t1_c3_data",     70'(r1_if.resp_data),  70'(row_of(rb)));
    check("t1_c3_put_vld",  70'(mem_if.req_valid), 70'(0));
    tick();
    #1;
    check("t1_c4_r1_resp",  70'(r1_if.resp_valid), 70'(0));

    // Streaming: r0 alone gets one grant per cycle.
    r0_if.req_valid = 1'b1; r0_if.req_data = rc;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (r0_if.req_ready) grants++;
      if (i == 0 || i == 9)
        check($sformatf("t2_resp_%0d", i), 70'(r0_if.resp_valid), 70'(i != 0));
      tick();
    end
    check("t2_grants", 70'(grants), 70'(10));
    r0_if.req_valid = 1'b0;
    #1;
    check("t2_last_resp", 70'(r0_if.resp_valid), 70'(1));
    check("t2_last_data", 70'(r0_if.resp_data),  70'(row_of(rc)));
    check_stats("t2", 11, 1, 1);
    tick();

    // Owner stalls its response: r1 is held off until r0 consumes.
    r0_if.req_valid = 1'b1; r0_if.req_data = rd; r0_if.resp_ready = 1'b0;
    #1;
    check("t3_r0_ready", 70'(r0_if.req_ready), 70'(1));
    tick();
    r0_if.req_valid = 1'b0;
    r1_if.req_valid = 1'b1; r1_if.req_data = re;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t3_hold_r1_ready_%0d", k), 70'(r1_if.req_ready),  70'(0));
      check($sformatf("t3_hold_get_vld_%0d", k),  70'(mem_if.resp_ready), 70'(0));
      check($sformatf("t3_hold_r0_resp_%0d", k),  70'(r0_if.resp_valid), 70'(1));
      tick();
    end
    r0_if.resp_ready = 1'b1;
    #1;
    check("t3_rel_r1_ready", 70'(r1_if.req_ready),  70'(1));
    check("t3_rel_get_vld",  70'(mem_if.resp_ready), 70'(1));
    check("t3_rel_data",     70'(r0_if.resp_data),  70'(row_of(rd)));
    tick();
    r1_if.req_valid = 1'b0;
    #1;
    check("t3_r1_resp", 70'(r1_if.resp_valid), 70'(1));
    check("t3_r1_data", 70'(r1_if.resp_data),  70'(row_of(re)));
    tick();

    // Fire-and-forget write from r1, then r0 wins the following conflict.
    r1_if.req_valid = 1'b1; r1_if.req_data = wr;
    #1;
    check("t4_wr_ready",   70'(r1_if.req_ready), 70'(1));
    check("t4_wr_put_req", 70'(mem_if.req_data), 70'(wr));
    tick();
    r1_if.req_data = rf;
    r0_if.req_valid = 1'b1; r0_if.req_data = rg;
    #1;
    check("t4_no_r0_resp", 70'(r0_if.resp_valid), 70'(0));
    check("t4_no_r1_resp", 70'(r1_if.resp_valid), 70'(0));
    check("t4_r0_ready",   70'(r0_if.req_ready),  70'(1));
    check("t4_r1_ready",   70'(r1_if.req_ready),  70'(0));
    tick();
    r0_if.req_valid = 1'b0;
    #1;
    check("t4_r0_resp",  70'(r0_if.resp_valid), 70'(1));
    check("t4_r0_data",  70'(r0_if.resp_data),  70'(row_of(rg)));
    check("t4_r1_ready2", 70'(r1_if.req_ready), 70'(1));
    tick();
    r1_if.req_valid = 1'b0;
    #1;
    check("t4_r1_resp", 70'(r1_if.resp_valid), 70'(1));
    check_stats("t4", 13, 4, 2);

    // Asynchronous reset while r1 owns the outstanding response.
    #2 rst = 1'b1;
    #1;
    check("t5_async_r1_resp", 70'(r1_if.resp_valid),  70'(0));
    check("t5_async_get_vld", 70'(mem_if.resp_ready), 70'(0));
    check_stats("t5_async", 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_post_r1_resp", 70'(r1_if.resp_valid), 70'(0));
    r0_if.req_valid = 1'b1; r0_if.req_data = rh;
    r1_if.req_valid = 1'b1; r1_if.req_data = ri;
    #1;
    check("t5_r0_ready", 70'(r0_if.req_ready), 70'(1));
    check("t5_r1_ready", 70'(r1_if.req_ready), 70'(0));
    tick();

    // Cache not yet presenting the response: nothing moves.
    r0_if.req_valid = 1'b0;
    mem_if.resp_valid = 1'b0;
    #1;
    check("t6_r0_resp",   70'(r0_if.resp_valid),  70'(0));
    check("t6_r1_ready",  70'(r1_if.req_ready),   70'(0));
    check("t6_get_vld",   70'(mem_if.resp_ready), 70'(1));
    check("t6_put_vld",   70'(mem_if.req_valid),  70'(0));
    tick();
    mem_if.resp_valid = 1'b1;
    #1;
    check("t6_r0_resp2",  70'(r0_if.resp_valid), 70'(1));
    check("t6_r0_data",   70'(r0_if.resp_data),  70'(row_of(rh)));
    check("t6_r1_ready2", 70'(r1_if.req_ready),  70'(1));
    tick();

    // Cache refusing a put: valid is offered but nobody is accepted.
    r1_if.req_valid = 1'b0;
    r0_if.req_valid = 1'b1; r0_if.req_data = rj;
    mem_if.req_ready = 1'b0;
    #1;
    check("t7_r1_resp",  70'(r1_if.resp_valid), 70'(1));
    check("t7_put_vld",  70'(mem_if.req_valid), 70'(1));
    check("t7_r0_ready", 70'(r0_if.req_ready),  70'(0));
    check_stats("t7", 1, 1, 1);
    tick();
    mem_if.req_ready = 1'b1;
    #1;
    check("t7_idle_r0_ready", 70'(r0_if.req_ready),  70'(1));
    check("t7_idle_r1_resp",  70'(r1_if.resp_valid), 70'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
